// File: rtl/sram_share_ctrl.sv
// sram_share_ctrl: zero-fills a 1R1W SRAM macro after reset or flush, then
// shares its read port between two requesters (round-robin) and gates one writer.
// Ports:
//   clock, reset_n              clock and async active-low reset
//   flush                       start a zero-fill from RUN
//   init_done                   array initialised, traffic allowed
//   rd_valid/rd_addr0/rd_addr1  read requests
//   rd_ready                    one-hot read grants
//   rsp_valid/rsp_data          read responses, one cycle after accept
//   wr_valid/wr_addr/wr_data    write request
//   wr_ready                    write grant
//   mem_*                       macro read/write port controls and data
module sram_share_ctrl #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 49
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  output logic              init_done,
  input  logic [1:0]        rd_valid,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [1:0]        rd_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_ptr;
  logic [1:0]          r_rsp_valid;
  logic                r_byp;
  logic [DATA_W-1:0]   r_byp_data;
  logic [ADDR_W-1:0]   r_raddr;

  logic                w_run;
  logic                w_last;
  logic [1:0]          w_gnt;
  logic                w_acc;
  logic                w_sel;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_wacc;
  logic                w_hit;

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_cnt == LAST);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; flush is ignored while a fill is running
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FILL: if (w_last) w_next = S_RUN;
      S_RUN:  if (flush)  w_next = S_FILL;
      default: w_next = S_FILL;
    endcase
  end

  // Output / grant logic
  always_comb begin
    w_gnt = 2'b00;
    if (w_run) begin
      unique case (rd_valid)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        // r_ptr names the last winner; the other side goes next
        2'b11:   w_gnt = r_ptr ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
    w_acc  = |w_gnt;
    w_sel  = w_gnt[1];
    w_addr = w_sel ? rd_addr1 : rd_addr0;
    w_wacc = w_run && wr_valid;
    w_hit  = w_acc && w_wacc && (wr_addr == w_addr);

    init_done = w_run;
    rd_ready  = w_gnt;
    wr_ready  = w_run;
    mem_ren   = w_acc;
    mem_raddr = w_acc ? w_addr : r_raddr;
    if (w_run) begin
      mem_wen   = wr_valid;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
    end else begin
      mem_wen   = 1'b1;
      mem_waddr = r_cnt;
      mem_wdata = '0;
    end
    rsp_valid = r_rsp_valid;
    rsp_data  = r_byp ? r_byp_data : mem_rdata;
  end

  // Fill counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!w_run && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Arbitration pointer and held read address
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= 1'b1;
      r_raddr <= '0;
    end else if (w_acc) begin
      r_ptr   <= w_sel;
      r_raddr <= w_addr;
    end
  end

  // Response strobe and same-address bypass
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 2'b00;
      r_byp       <= 1'b0;
      r_byp_data  <= '0;
    end else begin
      r_rsp_valid <= w_gnt;
      r_byp       <= w_hit;
      if (w_hit) r_byp_data <= wr_data;
    end
  end

endmodule
